// File: rtl/wb_interconnect.sv
// Single-master, N-slave Wishbone interconnect.
// Decodes the master address against per-slave base/mask windows, runs one
// transaction at a time, and returns a registered ack or a bus error. Errors
// come from unmapped addresses or from a slave that never acks.

// Window comparator for one slave port.
module wb_ic_win_match #(
  parameter int addr_width = 32
) (
  input  logic [addr_width-1:0] adr,
  input  logic [addr_width-1:0] base,
  input  logic [addr_width-1:0] mask,
  output logic                  hit
);
  assign hit = ((adr & mask) == (base & mask));
endmodule

module wb_interconnect #(
  parameter int                             addr_width     = 32,
  parameter int                             data_width     = 32,
  parameter int                             num_slaves     = 4,
  parameter logic [num_slaves*addr_width-1:0] slave_base   = '0,
  parameter logic [num_slaves*addr_width-1:0] slave_mask   = '0,
  parameter int                             timeout_cycles = 255,
  parameter logic [data_width-1:0]          timeout_data   = data_width'(32'hDEADBEEF)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [addr_width-1:0]            m_adr,
  input  logic [data_width-1:0]            m_datwr,
  input  logic                             m_we,
  input  logic [data_width/8-1:0]          m_sel,
  input  logic                             m_stb,
  input  logic                             m_cyc,
  output logic [data_width-1:0]            m_datrd,
  output logic                             m_ack,
  output logic                             m_err,
  output logic [addr_width-1:0]            s_adr,
  output logic [data_width-1:0]            s_datwr,
  output logic                             s_we,
  output logic [data_width/8-1:0]          s_sel,
  output logic [num_slaves-1:0]            s_stb,
  output logic [num_slaves-1:0]            s_cyc,
  input  logic [num_slaves*data_width-1:0] s_datrd,
  input  logic [num_slaves-1:0]            s_ack,
  output logic [7:0]                       err_count
);

  localparam int          strobe_width = data_width / 8;
  localparam int          idx_w        = (num_slaves > 1) ? $clog2(num_slaves) : 1;
  // The counter holds the number of ACCESS cycles already spent, so the
  // cycle that sees timeout_cycles-1 is the last one allowed.
  localparam logic [15:0] tmo_last     = 16'(timeout_cycles - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state, state_nxt;
  logic [num_slaves-1:0]   hit_vec;
  logic                    hit;
  logic [idx_w-1:0]        hit_idx;

  logic [idx_w-1:0]        idx, idx_nxt;
  logic [15:0]             tmo_cnt, tmo_nxt;
  logic [addr_width-1:0]   s_adr_nxt;
  logic [data_width-1:0]   s_datwr_nxt;
  logic                    s_we_nxt;
  logic [strobe_width-1:0] s_sel_nxt;
  logic [num_slaves-1:0]   s_stb_nxt;
  logic [data_width-1:0]   m_datrd_nxt;
  logic                    m_ack_nxt, m_err_nxt;

  // One window comparator per slave port.
  for (genvar i = 0; i < num_slaves; i++) begin : g_win
    wb_ic_win_match #(.addr_width(addr_width)) u_win (
      .adr  (m_adr),
      .base (slave_base[i*addr_width +: addr_width]),
      .mask (slave_mask[i*addr_width +: addr_width]),
      .hit  (hit_vec[i])
    );
  end

  // Priority encode: scan high to low so the lowest matching index wins.
  always_comb begin
    hit     = |hit_vec;
    hit_idx = '0;
    for (int i = num_slaves - 1; i >= 0; i--)
      if (hit_vec[i]) hit_idx = idx_w'(i);
  end

  assign s_cyc = s_stb;

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    tmo_nxt     = tmo_cnt;
    s_adr_nxt   = s_adr;
    s_datwr_nxt = s_datwr;
    s_we_nxt    = s_we;
    s_sel_nxt   = s_sel;
    s_stb_nxt   = s_stb;
    m_datrd_nxt = m_datrd;
    m_ack_nxt   = 1'b0;
    m_err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        tmo_nxt = '0;
        if (m_cyc && m_stb) begin
          s_adr_nxt   = m_adr;
          s_datwr_nxt = m_datwr;
          s_we_nxt    = m_we;
          s_sel_nxt   = m_sel;
          if (hit) begin
            idx_nxt   = hit_idx;
            s_stb_nxt = num_slaves'(1) << hit_idx;
            state_nxt = ACCESS;
          end else begin
            m_err_nxt   = 1'b1;
            m_datrd_nxt = timeout_data;
            state_nxt   = RESP;
          end
        end
      end
      ACCESS: begin
        if (!m_cyc) begin
          // Master abandoned the cycle: release the slave silently.
          s_stb_nxt = '0;
          tmo_nxt   = '0;
          state_nxt = IDLE;
        end else if (s_ack[idx]) begin
          m_ack_nxt   = 1'b1;
          m_datrd_nxt = s_datrd[idx*data_width +: data_width];
          s_stb_nxt   = '0;
          state_nxt   = RESP;
        end else if (tmo_cnt == tmo_last) begin
          m_err_nxt   = 1'b1;
          m_datrd_nxt = timeout_data;
          s_stb_nxt   = '0;
          state_nxt   = RESP;
        end else begin
          tmo_nxt = tmo_cnt + 16'd1;
        end
      end
      RESP: begin
        tmo_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        s_stb_nxt = '0;
        tmo_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  // Datapath, response and error-count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      tmo_cnt   <= '0;
      s_adr     <= '0;
      s_datwr   <= '0;
      s_we      <= 1'b0;
      s_sel     <= '0;
      s_stb     <= '0;
      m_datrd   <= '0;
      m_ack     <= 1'b0;
      m_err     <= 1'b0;
      err_count <= '0;
    end else begin
      idx     <= idx_nxt;
      tmo_cnt <= tmo_nxt;
      s_adr   <= s_adr_nxt;
      s_datwr <= s_datwr_nxt;
      s_we    <= s_we_nxt;
      s_sel   <= s_sel_nxt;
      s_stb   <= s_stb_nxt;
      m_datrd <= m_datrd_nxt;
      m_ack   <= m_ack_nxt;
      m_err   <= m_err_nxt;
      if (m_err_nxt && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// Bench for wb_interconnect: two slaves, decoded and fully-overlapping maps.
module tb_wb_interconnect;
  logic        clock = 1'b0, reset = 1'b1;
  logic [31:0] m_adr = '0, m_datwr = '0;
  logic        m_we = 1'b0, m_stb = 1'b0, m_cyc = 1'b0;
  logic [3:0]  m_sel = '0;
  logic [63:0] s_datrd = {32'h0BAD_F00D, 32'h1234_5678};
  logic [1:0]  s_ack = '0;

  logic [31:0] m_datrd, s_adr, s_datwr;
  logic        m_ack, m_err, s_we;
  logic [3:0]  s_sel;
  logic [1:0]  s_stb, s_cyc;
  logic [7:0]  err_count;

  logic [31:0] ov_m_datrd, ov_s_adr, ov_s_datwr;
  logic        ov_m_ack, ov_m_err, ov_s_we;
  logic [3:0]  ov_s_sel;
  logic [1:0]  ov_s_stb, ov_s_cyc;
  logic [7:0]  ov_err_count;

  int total = 0, bad = 0, cyc = 0;

  typedef struct { logic ack; logic err; logic [31:0] data; int at; } resp_t;
  resp_t sb[$];

  wb_interconnect #(
    .addr_width(32), .data_width(32), .num_slaves(2),
    .slave_base({32'h8000_0000, 32'h0000_0000}),
    .slave_mask({32'hF000_0000, 32'hF000_0000}),
    .timeout_cycles(8), .timeout_data(32'hDEADBEEF)
  ) dut (
    .clock(clock), .reset(reset), .m_adr(m_adr), .m_datwr(m_datwr), .m_we(m_we),
    .m_sel(m_sel), .m_stb(m_stb), .m_cyc(m_cyc), .m_datrd(m_datrd), .m_ack(m_ack),
    .m_err(m_err), .s_adr(s_adr), .s_datwr(s_datwr), .s_we(s_we), .s_sel(s_sel),
    .s_stb(s_stb), .s_cyc(s_cyc), .s_datrd(s_datrd), .s_ack(s_ack), .err_count(err_count)
  );

  wb_interconnect #(
    .addr_width(32), .data_width(32), .num_slaves(2),
    .slave_base({32'h0, 32'h0}), .slave_mask({32'h0, 32'h0}),
    .timeout_cycles(8), .timeout_data(32'hDEADBEEF)
  ) dut_ov (
    .clock(clock), .reset(reset), .m_adr(m_adr), .m_datwr(m_datwr), .m_we(m_we),
    .m_sel(m_sel), .m_stb(m_stb), .m_cyc(m_cyc), .m_datrd(ov_m_datrd), .m_ack(ov_m_ack),
    .m_err(ov_m_err), .s_adr(ov_s_adr), .s_datwr(ov_s_datwr), .s_we(ov_s_we), .s_sel(ov_s_sel),
    .s_stb(ov_s_stb), .s_cyc(ov_s_cyc), .s_datrd(s_datrd), .s_ack(s_ack), .err_count(ov_err_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: every ack/err pulse must match the next expected response.
  always @(negedge clock) begin
    resp_t e;
    if (m_ack === 1'b1 || m_err === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected ack=%b err=%b data=%h cyc=%0d", m_ack, m_err, m_datrd, cyc);
      end else begin
        e = sb.pop_front();
        if (m_ack !== e.ack || m_err !== e.err || m_datrd !== e.data || cyc != e.at) begin
          bad++;
          $display("FAIL resp got ack=%b err=%b data=%h cyc=%0d want ack=%b err=%b data=%h cyc=%0d",
                   m_ack, m_err, m_datrd, cyc, e.ack, e.err, e.data, e.at);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clock); #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic we);
    m_adr = a; m_datwr = d; m_we = we; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
  endtask

  task automatic drop();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({m_ack, m_err, m_datrd} !== 34'h0) begin bad++;
      $display("FAIL rst_resp got ack=%b err=%b data=%h want 0", m_ack, m_err, m_datrd); end
    total++;
    if ({s_stb, s_cyc} !== 4'h0) begin bad++;
      $display("FAIL rst_stb got stb=%b cyc=%b want 0", s_stb, s_cyc); end
    total++;
    if ({s_adr, s_datwr, s_sel, s_we} !== 69'h0) begin bad++;
      $display("FAIL rst_bus got adr=%h dat=%h sel=%h we=%b want 0", s_adr, s_datwr, s_sel, s_we); end
    total++;
    if (err_count !== 8'd0) begin bad++;
      $display("FAIL rst_errcnt got %0d want 0", err_count); end
    @(posedge clock); #1 reset = 1'b1;
    nxt();
  endtask

  task automatic test_write();
    int c0;
    nxt(); c0 = cyc;
    req(32'h8000_0010, 32'hA5A5_0001, 1'b1);
    sb.push_back('{1'b1, 1'b0, 32'h0BAD_F00D, c0 + 5});
    nxt(); @(negedge clock);
    total++;
    if (s_stb !== 2'b10 || s_cyc !== 2'b10) begin bad++;
      $display("FAIL wr_stb got stb=%b cyc=%b want 10", s_stb, s_cyc); end
    total++;
    if (s_adr !== 32'h8000_0010 || s_datwr !== 32'hA5A5_0001 || s_we !== 1'b1 || s_sel !== 4'hF) begin bad++;
      $display("FAIL wr_bus got adr=%h dat=%h we=%b sel=%h", s_adr, s_datwr, s_we, s_sel); end
    nxt(); nxt(); nxt();
    s_ack = 2'b10;
    @(negedge clock);
    total++;
    if (m_ack !== 1'b0 || s_stb !== 2'b10) begin bad++;
      $display("FAIL wr_wait got ack=%b stb=%b want 0/10", m_ack, s_stb); end
    nxt(); s_ack = 2'b00;
    @(negedge clock);
    total++;
    if (s_stb !== 2'b00) begin bad++;
      $display("FAIL wr_stb_drop got %b want 00", s_stb); end
    drop();
    nxt(); @(negedge clock);
    total++;
    if (m_ack !== 1'b0 || m_err !== 1'b0) begin bad++;
      $display("FAIL wr_pulse got ack=%b err=%b want 0/0", m_ack, m_err); end
  endtask

  task automatic test_read_s0();
    int c0;
    nxt(); c0 = cyc;
    req(32'h0000_0004, 32'h0, 1'b0);
    sb.push_back('{1'b1, 1'b0, 32'h1234_5678, c0 + 2});
    nxt(); @(negedge clock);
    total++;
    if (s_stb !== 2'b01) begin bad++;
      $display("FAIL rd_stb got %b want 01", s_stb); end
    s_ack = 2'b01;
    nxt(); s_ack = 2'b00;
    @(negedge clock);
    total++;
    if (s_stb !== 2'b00) begin bad++;
      $display("FAIL rd_stb_drop got %b want 00", s_stb); end
    drop();
    nxt();
  endtask

  task automatic test_unmapped();
    int c0;
    nxt(); c0 = cyc;
    req(32'h4000_0000, 32'h0, 1'b0);
    sb.push_back('{1'b0, 1'b1, 32'hDEADBEEF, c0 + 1});
    nxt(); @(negedge clock);
    total++;
    if (s_stb !== 2'b00) begin bad++;
      $display("FAIL unm_stb got %b want 00", s_stb); end
    drop();
    nxt(); @(negedge clock);
    total++;
    if (err_count !== 8'd1) begin bad++;
      $display("FAIL unm_errcnt got %0d want 1", err_count); end
  endtask

  task automatic test_timeout();
    int c0;
    nxt(); c0 = cyc;
    req(32'h8000_0020, 32'h0, 1'b0);
    sb.push_back('{1'b0, 1'b1, 32'hDEADBEEF, c0 + 9});
    for (int k = 1; k <= 8; k++) begin
      nxt(); @(negedge clock);
      total++;
      if (s_stb !== 2'b10) begin bad++;
        $display("FAIL tmo_stb cycle %0d got %b want 10", k, s_stb); end
    end
    nxt(); s_ack = 2'b10;
    @(negedge clock);
    total++;
    if (s_stb !== 2'b00) begin bad++;
      $display("FAIL tmo_stb_drop got %b want 00", s_stb); end
    drop();
    nxt(); @(negedge clock);
    total++;
    if (err_count !== 8'd2) begin bad++;
      $display("FAIL tmo_errcnt got %0d want 2", err_count); end
    nxt(); s_ack = 2'b00;
    nxt();
  endtask

  task automatic test_overlap_abort();
    int c0;
    nxt();
    req(32'h8000_0000, 32'h0, 1'b0);
    nxt(); @(negedge clock);
    total++;
    if (ov_s_stb !== 2'b01 || s_stb !== 2'b10) begin bad++;
      $display("FAIL ovl_sel got ov=%b main=%b want 01/10", ov_s_stb, s_stb); end
    nxt();
    nxt(); drop();
    @(negedge clock);
    total++;
    if (ov_s_stb !== 2'b01) begin bad++;
      $display("FAIL abt_hold got %b want 01", ov_s_stb); end
    for (int k = 0; k < 3; k++) begin
      nxt(); @(negedge clock);
      total++;
      if (ov_s_stb !== 2'b00 || ov_s_cyc !== 2'b00 || s_stb !== 2'b00 || ov_m_ack !== 1'b0 || ov_m_err !== 1'b0) begin bad++;
        $display("FAIL abt_quiet got ov_stb=%b ov_cyc=%b stb=%b ack=%b err=%b want all 0",
                 ov_s_stb, ov_s_cyc, s_stb, ov_m_ack, ov_m_err); end
    end
    // A fresh request right after the abort must complete at full speed.
    nxt(); c0 = cyc;
    req(32'h0000_0004, 32'h0, 1'b0);
    sb.push_back('{1'b1, 1'b0, 32'h1234_5678, c0 + 2});
    nxt(); @(negedge clock);
    s_ack = 2'b01;
    nxt(); s_ack = 2'b00;
    @(negedge clock);
    total++;
    if (ov_m_ack !== 1'b1 || ov_m_datrd !== 32'h1234_5678) begin bad++;
      $display("FAIL abt_next got ack=%b data=%h want 1/12345678", ov_m_ack, ov_m_datrd); end
    drop();
    nxt();
  endtask

  task automatic test_reset_mid();
    nxt();
    req(32'h0000_0008, 32'h0, 1'b0);
    nxt(); @(negedge clock);
    total++;
    if (s_stb !== 2'b01) begin bad++;
      $display("FAIL rmid_stb got %b want 01", s_stb); end
    #1 reset = 1'b0;
    #1;
    total++;
    if (s_stb !== 2'b00 || s_cyc !== 2'b00 || s_adr !== 32'h0 || m_datrd !== 32'h0 || err_count !== 8'd0) begin bad++;
      $display("FAIL rmid_clear got stb=%b cyc=%b adr=%h data=%h errcnt=%0d want all 0",
               s_stb, s_cyc, s_adr, m_datrd, err_count); end
    drop();
    nxt(); nxt();
    reset = 1'b1;
    nxt();
  endtask

  task automatic test_err_saturate();
    int c0;
    for (int n = 1; n <= 300; n++) begin
      nxt(); c0 = cyc;
      req(32'h4000_0000 + 32'(n), 32'h0, 1'b0);
      sb.push_back('{1'b0, 1'b1, 32'hDEADBEEF, c0 + 1});
      nxt(); @(negedge clock);
      drop();
      if (n == 254 || n == 300) begin
        total++;
        if (err_count !== ((n == 254) ? 8'd254 : 8'd255)) begin bad++;
          $display("FAIL sat_errcnt after %0d errors got %0d", n, err_count); end
      end
    end
    nxt(); nxt();
  endtask

  initial begin
    #2 reset = 1'b0;
    #20;
    test_reset();
    test_write();
    test_read_s0();
    test_unmapped();
    test_timeout();
    test_overlap_abort();
    test_reset_mid();
    test_read_s0();
    test_err_saturate();
    total++;
    if (sb.size() != 0) begin bad++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_interconnect.md
Name: wb_interconnect

Overview:
Parametrised single-master, N-slave Wishbone interconnect that replaces point-to-point cpu-to-peripheral wiring at the SoC top level. It sits between wb_copperv and the peripherals (wb2uart, memories, GPIO). It decodes the master address against per-slave base/mask windows and routes one transaction at a time. It registers the response back to the master and returns a bus error on unmapped addresses or on slave timeout.

Parameters:
- addr_width, 32, address bus width.
- data_width, 32, data bus width; strobe_width = data_width/8.
- num_slaves, 4, number of slave ports (1..16).
- slave_base, {num_slaves{32'h0}}, flat num_slaves*addr_width vector; slice i is the base of slave i.
- slave_mask, {num_slaves{32'h0}}, flat vector; slave i hits when (m_adr & mask_i) == (base_i & mask_i).
- timeout_cycles, 255, maximum cycles spent in ACCESS before an error is forced (1..2^16-1).
- timeout_data, 32'hDEADBEEF, value returned on m_datrd with any error response.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- m_adr  in  addr_width  master address.
- m_datwr  in  data_width  master write data.
- m_we  in  1  master write enable.
- m_sel  in  strobe_width  master byte select.
- m_stb  in  1  master strobe.
- m_cyc  in  1  master cycle.
- m_datrd  out  data_width  read data to master (registered).
- m_ack  out  1  transfer acknowledge (registered, 1-cycle pulse).
- m_err  out  1  bus error (registered, 1-cycle pulse).
- s_adr  out  addr_width  broadcast address (registered at accept).
- s_datwr  out  data_width  broadcast write data (registered).
- s_we  out  1  broadcast write enable (registered).
- s_sel  out  strobe_width  broadcast byte select (registered).
- s_stb  out  num_slaves  per-slave strobe, one-hot or zero.
- s_cyc  out  num_slaves  per-slave cycle, equal to s_stb.
- s_datrd  in  num_slaves*data_width  flat per-slave read data.
- s_ack  in  num_slaves  per-slave acknowledge.
- err_count  out  8  saturating count of error responses.

Behaviour:
- Reset (reset=0, async): state=IDLE. m_ack=0, m_err=0, m_datrd=0. s_stb=s_cyc=0. s_adr/s_datwr/s_sel/s_we=0. err_count=0. Timeout counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on m_cyc&m_stb, latch adr/datwr/we/sel into the s_* registers and decode.
  - Hit: take the lowest-index matching slave (overlapping windows resolve to the lowest index), latch its index, go to ACCESS.
  - No hit: go to RESP with m_err=1, m_datrd=timeout_data.
- ACCESS: s_stb[idx]=s_cyc[idx]=1; the timeout counter increments each cycle.
  - s_ack[idx]=1: capture s_datrd slice idx into m_datrd (also on writes), drop s_stb the next cycle, go to RESP with m_ack=1.
  - Counter reaches timeout_cycles with no ack: drop s_stb, go to RESP with m_err=1, m_datrd=timeout_data.
  - Ack and timeout in the same cycle: ack wins.
  - Acks from non-selected slaves are ignored in every state.
  - m_cyc falls during ACCESS (abort): drop s_stb/s_cyc next cycle, return to IDLE, no m_ack and no m_err.
- RESP: m_ack or m_err is high for exactly one cycle, then IDLE. The timeout counter clears.
  - The master must not present a new request in RESP; a request still asserted in the following IDLE cycle is accepted as new.
- Latency: request in IDLE at cycle 0 → s_stb high at cycle 1. A slave ack at cycle k gives m_ack at cycle k+1. Minimum read/write latency is 2 cycles. Unmapped error: m_err at cycle 1.
- m_ack and m_err are never high together.
- err_count increments on each m_err pulse and saturates at 255.
- Only one transaction is outstanding; no pipelining and no burst (CTI/BTE unsupported).
- Reset assertion mid-ACCESS drops s_stb immediately (async); no response is issued.

Test Plan:
- num_slaves=2, slave1 base 0x8000_0000 mask 0xF000_0000; write 0x8000_0010 data 0xA5A5_0001 sel 4'hF; slave acks 3 cycles after stb → s_stb=2'b10, s_datwr=0xA5A5_0001, m_ack single pulse one cycle after s_ack, m_err=0.
- Read 0x0000_0004 from slave0 returning 0x1234_5678 with immediate ack → m_datrd=0x1234_5678 with m_ack 2 cycles after request; s_stb[1] never asserts.
- Read 0x4000_0000 (unmapped) → m_err pulse at cycle 1, m_datrd=0xDEADBEEF, no s_stb, err_count=1.
- timeout_cycles=8, slave never acks → s_stb high for 8 cycles, then m_err with 0xDEADBEEF; a late s_ack is ignored.
- Overlapping windows (both slaves base 0, mask 0) → slave0 selected; m_cyc dropped after 2 ACCESS cycles → s_stb low next cycle, no m_ack/m_err, FSM returns to IDLE.
- Async reset pulse mid-ACCESS → all outputs 0 immediately; after release, a fresh read completes normally; 300 forced errors → err_count=255.
